// File: rtl/gpin_scan_pkg.sv
// Shared definitions for the general-purpose input scanner.
// Holds the register index map, the FSM state encoding and the CTRL
// register layout used by peripheral_gpin_scan.
package gpin_scan_pkg;

  // Register indices (4 LSBs of the J1 I/O address)
  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_PERIOD  = 4'h1;
  localparam logic [3:0] ADDR_STATUS  = 4'h2;
  localparam logic [3:0] ADDR_CHANGED = 4'h3;
  localparam logic [3:0] ADDR_SNAP0   = 4'h4;
  localparam logic [3:0] ADDR_SNAP1   = 4'h5;
  localparam logic [3:0] ADDR_SNAP2   = 4'h6;
  localparam logic [3:0] ADDR_SNAP3   = 4'h7;

  // Scan FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_S0     = 3'd2;
  localparam logic [2:0] ST_S1     = 3'd3;
  localparam logic [2:0] ST_S2     = 3'd4;
  localparam logic [2:0] ST_S3     = 3'd5;
  localparam logic [2:0] ST_COMMIT = 3'd6;

  // CTRL register bits
  typedef struct packed {
    logic irq_en;
    logic enable;
  } ctrl_t;

  // busy covers the capture states and COMMIT
  function automatic logic state_busy(input logic [2:0] st);
    return (st == ST_S0) || (st == ST_S1) || (st == ST_S2) ||
           (st == ST_S3) || (st == ST_COMMIT);
  endfunction

endpackage

// File: rtl/gpin_scan_timer.sv
// Scan-interval countdown.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val (has priority over dec)
//   load_val  - reload value
//   dec       - decrement by one (saturates at 0)
//   zero      - count is 0
module gpin_scan_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [PERIOD_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                      count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - PERIOD_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/peripheral_gpin_scan.sv
// Periodic snapshot scanner for four 16-bit input channels on the J1 I/O bus.
// Every PERIOD+5 cycles the channels are captured one per cycle into shadow
// registers, then committed to SNAP0..3 together; channels that differ from
// the previous snapshot are flagged in CHANGED and raise irq (if enabled).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cs, addr, rd, wr  - register access (write on cs&&wr, read on cs&&rd)
//   d_in / d_out      - write data / registered read data (0 when not read)
//   gp_in0..gp_in3    - external input channels
//   irq               - registered level interrupt (irq_en && chg)
module peripheral_gpin_scan
  import gpin_scan_pkg::*;
#(
  parameter int PERIOD_W = 16  // 8..16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  input  logic [15:0] gp_in0,
  input  logic [15:0] gp_in1,
  input  logic [15:0] gp_in2,
  input  logic [15:0] gp_in3,
  output logic        irq
);

  ctrl_t               ctrl;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          changed;
  logic [3:0][15:0]    shadow;
  logic [3:0][15:0]    snap;
  logic [2:0]          state, state_nx;
  logic                prime;  // next COMMIT is the priming scan

  logic                wr_en, rd_en, chg, busy;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [PERIOD_W-1:0] reload_val;
  logic [3:0]          hw_set, clr;
  logic [15:0]         rd_data;

  assign wr_en = cs && wr;
  assign rd_en = cs && rd;
  assign chg   = |changed;
  assign busy  = state_busy(state);

  // PERIOD=0 behaves like PERIOD=1
  assign reload_val = (period == '0) ? '0 : period - PERIOD_W'(1);

  gpin_scan_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (reload_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state / timer control
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state)
      ST_IDLE: if (ctrl.enable) begin
        state_nx = ST_WAIT;
        tmr_load = 1'b1;
      end
      ST_WAIT: begin
        if (!ctrl.enable)  state_nx = ST_IDLE;
        else if (tmr_zero) state_nx = ST_S0;
        else               tmr_dec  = 1'b1;
      end
      ST_S0: state_nx = ST_S1;
      ST_S1: state_nx = ST_S2;
      ST_S2: state_nx = ST_S3;
      ST_S3: state_nx = ST_COMMIT;
      ST_COMMIT: begin
        if (ctrl.enable) begin
          state_nx = ST_WAIT;
          tmr_load = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Change detection and W1C clears. Clearing chg in STATUS clears every
  // CHANGED bit so chg stays the OR of CHANGED. Sets are OR-ed in after the
  // clear so a coincident hardware set survives.
  always_comb begin
    hw_set = '0;
    if (state == ST_COMMIT && !prime)
      for (int n = 0; n < 4; n++) hw_set[n] = (shadow[n] != snap[n]);
    clr = '0;
    if (wr_en && addr == ADDR_CHANGED)          clr = d_in[3:0];
    if (wr_en && addr == ADDR_STATUS && d_in[1]) clr = 4'hF;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_CTRL:    rd_data[1:0] = {ctrl.irq_en, ctrl.enable};
      ADDR_PERIOD:  rd_data[PERIOD_W-1:0] = period;
      ADDR_STATUS:  rd_data[1:0] = {chg, busy};
      ADDR_CHANGED: rd_data[3:0] = changed;
      ADDR_SNAP0, ADDR_SNAP1, ADDR_SNAP2, ADDR_SNAP3:
                    rd_data = snap[addr[1:0]];
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ctrl    <= '0;
      period  <= '0;
      changed <= '0;
      shadow  <= '0;
      snap    <= '0;
      prime   <= 1'b0;
      irq     <= 1'b0;
      d_out   <= '0;
    end else begin
      state <= state_nx;
      if (wr_en && addr == ADDR_CTRL)   ctrl   <= ctrl_t'(d_in[1:0]);
      // the running count is untouched; new PERIOD applies at next reload
      if (wr_en && addr == ADDR_PERIOD) period <= d_in[PERIOD_W-1:0];
      changed <= (changed & ~clr) | hw_set;
      case (state)
        ST_S0: shadow[0] <= gp_in0;
        ST_S1: shadow[1] <= gp_in1;
        ST_S2: shadow[2] <= gp_in2;
        ST_S3: shadow[3] <= gp_in3;
        default: ;
      endcase
      if (state == ST_COMMIT) snap <= shadow;
      if (state == ST_IDLE && ctrl.enable) prime <= 1'b1;
      else if (state == ST_COMMIT)         prime <= 1'b0;
      irq   <= ctrl.irq_en && chg;
      d_out <= rd_en ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_peripheral_gpin_scan.sv
module tb_peripheral_gpin_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] d_in = '0;
  logic [15:0] d_out;
  logic        irq;
  logic [15:0] gp_m [4];

  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  logic [15:0] snap_m [4];
  logic [3:0]  chd_m;
  bit          prime_m;

  peripheral_gpin_scan #(.PERIOD_W(16)) dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_in(d_in), .d_out(d_out),
    .gp_in0(gp_m[0]), .gp_in1(gp_m[1]), .gp_in2(gp_m[2]), .gp_in3(gp_m[3]),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // all bus tasks start and end just after a falling edge
  task automatic bus_wr(input logic [3:0] a, input logic [15:0] d, output int ec);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(posedge clk); @(negedge clk);
    ec = cyc;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [15:0] v);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); @(negedge clk);
    v = d_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Polls STATUS every cycle; the read data trails the FSM by one cycle,
  // so the last busy cycle (COMMIT) is two edges before busy reads 0.
  task automatic wait_commit(input int maxc, output int c, output logic irq_b, output logic irq_a);
    logic prev = 1'b0, irq_p = 1'b0, found = 1'b0;
    c = cyc; irq_b = 1'b0; irq_a = 1'b0;
    cs = 1'b1; rd = 1'b1; addr = 4'h2;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); @(negedge clk);
      if (prev && !d_out[0]) begin
        found = 1'b1; c = cyc - 2; irq_b = irq_p; irq_a = irq;
        break;
      end
      prev = d_out[0]; irq_p = irq;
    end
    cs = 1'b0; rd = 1'b0;
    chk("commit_timeout", 32'(found), 32'd1);
  endtask

  // A commit copies every channel; outside a priming scan, any channel that
  // differs from its previous snapshot gets flagged.
  task automatic model_commit();
    for (int n = 0; n < 4; n++) begin
      if (!prime_m && gp_m[n] != snap_m[n]) chd_m[n] = 1'b1;
      snap_m[n] = gp_m[n];
    end
    prime_m = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    logic        ib, ia;
    int w, c, cp, ca, cb, k;
    logic [3:0] mask;

    gp_m[0] = 16'h00A5; gp_m[1] = 16'($urandom);
    gp_m[2] = 16'h0000; gp_m[3] = 16'($urandom);
    for (int n = 0; n < 4; n++) snap_m[n] = '0;
    chd_m = '0; prime_m = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(d_out), 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    bus_rd(4'h0, v); chk("rst_ctrl", 32'(v), 0);
    bus_rd(4'h1, v); chk("rst_period", 32'(v), 0);
    bus_rd(4'h2, v); chk("rst_status", 32'(v), 0);
    bus_rd(4'h3, v); chk("rst_changed", 32'(v), 0);
    bus_rd(4'h4, v); chk("rst_snap0", 32'(v), 0);
    bus_rd(4'h9, v); chk("unmapped_rd", 32'(v), 0);

    // Test 1: priming scan, PERIOD=3
    bus_wr(4'h1, 16'd3, w);
    bus_wr(4'h0, 16'h0003, w); prime_m = 1'b1;
    wait_commit(50, c, ib, ia);
    chk("t1_latency", 32'(c - w), 8);
    model_commit();
    gp_m[2] = 16'h1234;
    bus_wr(4'h1, 16'd20, w);  // lands during WAIT: current count must run on
    bus_rd(4'h4, v); chk("t1_snap0", 32'(v), 32'h00A5);
    bus_rd(4'h3, v); chk("t1_changed", 32'(v), 32'(chd_m));
    chk("t1_irq", 32'(irq), 0);
    cp = c;

    // Test 2: gp_in2 change flagged, irq one cycle after chg
    wait_commit(50, c, ib, ia);
    chk("t2_interval_old_period", 32'(c - cp), 8);
    chk("t2_irq_before", 32'(ib), 0);
    chk("t2_irq_after", 32'(ia), 1);
    model_commit();
    bus_rd(4'h3, v); chk("t2_changed", 32'(v), 32'h4);
    chk("t2_changed_model", 32'(v), 32'(chd_m));
    bus_rd(4'h2, v); chk("t2_chg", 32'(v[1]), 1);
    cp = c;

    // Test 3: W1C of chg coinciding with a hardware set
    bus_wr(4'h3, 16'h000F, w); chd_m = '0;
    gp_m[1] = gp_m[1] ^ 16'h0101;
    bus_rd(4'h2, v); chk("t3_chg_cleared", 32'(v[1]), 0);
    wait_to(cp + 25);
    bus_wr(4'h2, 16'h0002, w);
    model_commit();
    cp = cp + 25;
    bus_rd(4'h3, v); chk("t3_changed", 32'(v), 32'(chd_m));
    bus_rd(4'h2, v); chk("t3_chg", 32'(v[1]), 1);

    // randomized scans against the model
    for (int n = 0; n < 4; n++) gp_m[n] = 16'($urandom);
    for (int it = 0; it < 6; it++) begin
      wait_commit(100, c, ib, ia);
      chk("rnd_interval", 32'(c - cp), 25);
      model_commit();
      cp = c;
      bus_rd(4'h3, v); chk("rnd_changed", 32'(v), 32'(chd_m));
      k = $urandom_range(0, 3);
      bus_rd(4'(4 + k), v); chk("rnd_snap", 32'(v), 32'(snap_m[k]));
      bus_rd(4'h2, v); chk("rnd_chg", 32'(v[1]), 32'(|chd_m));
      mask = 4'($urandom_range(0, 15));
      bus_wr(4'h3, {12'h0, mask}, w); chd_m &= ~mask;
      for (int n = 0; n < 4; n++) if ($urandom_range(0, 1) == 1) gp_m[n] = 16'($urandom);
    end

    // Test 4: PERIOD=0 and PERIOD=0xFFFF intervals
    bus_wr(4'h1, 16'd0, w);
    wait_commit(100, ca, ib, ia); model_commit();
    chk("t4_interval_prev", 32'(ca - cp), 25);
    wait_commit(100, cb, ib, ia); model_commit();
    chk("t4_interval_p0", 32'(cb - ca), 6);
    bus_wr(4'h1, 16'hFFFF, w);
    wait_commit(100, ca, ib, ia); model_commit();
    chk("t4_interval_p0_again", 32'(ca - cb), 6);
    wait_commit(70000, cb, ib, ia); model_commit();
    chk("t4_interval_pmax", 32'(cb - ca), 65540);
    bus_rd(4'h3, v); chk("t4_changed", 32'(v), 32'(chd_m));
    bus_wr(4'h0, 16'h0002, w);  // disable during WAIT

    // Test 5: disable during S1, scan must still commit
    bus_wr(4'h1, 16'd2, w);
    bus_wr(4'h0, 16'h0003, w); prime_m = 1'b1;
    wait_commit(100, c, ib, ia);
    chk("t5_restart_latency", 32'(c - w), 7);
    model_commit();
    gp_m[0] = ~gp_m[0];
    wait_to(c + 4);
    bus_wr(4'h0, 16'h0002, w);
    model_commit();
    wait_to(c + 10);
    bus_rd(4'h2, v); chk("t5_status", 32'(v), 32'({|chd_m, 1'b0}));
    bus_rd(4'h4, v); chk("t5_snap0", 32'(v), 32'(snap_m[0]));
    bus_rd(4'h3, v); chk("t5_changed", 32'(v), 32'(chd_m));
    gp_m[0] = gp_m[0] ^ 16'hFFFF;
    wait_to(cyc + 20);
    bus_rd(4'h4, v); chk("t5_idle_snap0", 32'(v), 32'(snap_m[0]));
    bus_rd(4'h2, v); chk("t5_idle_busy", 32'(v[0]), 0);

    // Test 6: reset in S2
    bus_wr(4'h0, 16'h0003, w);
    wait_to(w + 5);
    rst = 1'b1; cs = 1'b1; rd = 1'b1; addr = 4'h4;
    @(posedge clk); @(negedge clk);
    chk("t6_dout", 32'(d_out), 0);
    chk("t6_irq", 32'(irq), 0);
    rst = 1'b0; cs = 1'b0; rd = 1'b0;
    bus_rd(4'h0, v); chk("t6_ctrl", 32'(v), 0);
    bus_rd(4'h1, v); chk("t6_period", 32'(v), 0);
    bus_rd(4'h2, v); chk("t6_status", 32'(v), 0);
    bus_rd(4'h3, v); chk("t6_changed", 32'(v), 0);
    for (int n = 0; n < 4; n++) begin
      bus_rd(4'(4 + n), v); chk("t6_snap", 32'(v), 0);
    end
    wait_to(cyc + 20);
    bus_rd(4'h2, v); chk("t6_idle_status", 32'(v), 0);
    bus_rd(4'h4, v); chk("t6_idle_snap0", 32'(v), 0);
    chk("t6_idle_irq", 32'(irq), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
